// File: rtl/neural_stage_bias_seq.sv
// Bias sequencer: pairs each accumulated value with its neuron's bias for the shared
// adder, then queues the adder's registered sum in a small credit-checked output FIFO.
module neural_stage_bias_seq #(
  parameter int NEURONS    = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W     = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             bias_wr_en,
  input  logic [IDX_W-1:0] bias_wr_addr,
  input  logic [31:0]      bias_wr_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_inflight;
  logic [IDX_W-1:0] r_tag_idx;
  logic             r_tag_last;
  logic             r_done;
  logic             r_err;

  logic [31:0]      r_bias      [NEURONS];
  logic [31:0]      r_fifo_data [FIFO_DEPTH];
  logic [IDX_W-1:0] r_fifo_idx  [FIFO_DEPTH];
  logic             r_fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_idle;
  logic             w_accept;
  logic             w_last_idx;
  logic             w_push;
  logic             w_pop;
  logic             w_bias_we;
  logic [CNT_W:0]   w_outstanding;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;

  assign w_idle     = (r_state == S_IDLE);
  assign w_last_idx = (r_idx == IDX_W'(NEURONS - 1));

  // Credit covers the FIFO plus the one sum still inside the adder, so a push can never overflow.
  assign w_outstanding = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign in_ready      = (r_state == S_RUN) && (w_outstanding < (CNT_W + 1)'(FIFO_DEPTH));
  assign w_accept      = in_valid && in_ready;

  assign add_a = w_accept ? in_data       : 32'd0;
  assign add_b = w_accept ? r_bias[r_idx] : 32'd0;

  assign w_push = r_inflight;
  assign w_pop  = out_valid && out_ready;

  assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

  assign out_valid = (r_count != '0);
  assign out_data  = r_fifo_data[r_rd_ptr];
  assign out_index = r_fifo_idx[r_rd_ptr];
  assign out_last  = r_fifo_last[r_rd_ptr];

  assign busy = !w_idle;
  assign done = r_done;
  assign err  = r_err;

  assign w_bias_we = bias_wr_en && w_idle && (int'(bias_wr_addr) < NEURONS);

  // NOTE: the bias table is a plain register file with no reset; software must load it before use.
  always_ff @(posedge clk) begin
    if (w_bias_we) begin
      r_bias[bias_wr_addr] <= bias_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_inflight <= 1'b0;
      r_tag_idx  <= '0;
      r_tag_last <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_accept;
      if (w_accept) begin
        r_tag_idx  <= r_idx;
        r_tag_last <= w_last_idx;
      end

      if (!w_idle && (bias_wr_en || cfg_start)) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_state <= S_RUN;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_last_idx) begin
              r_state <= S_DRAIN;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // NOTE: done is registered so it lands exactly on the first IDLE cycle, glitch-free.
          if (!r_inflight && (r_count == '0)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The FIFO storage is tiny and drives the outputs directly, so it is reset to give clean zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_idx[i]  <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= add_result;
        r_fifo_idx[r_wr_ptr]  <= r_tag_idx;
        r_fifo_last[r_wr_ptr] <= r_tag_last;
        r_wr_ptr              <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neural_stage_bias_seq.sv
// Bench for neural_stage_bias_seq: real-valued adder and output-order model, directed frames.
module tb_neural_stage_bias_seq;

  localparam int NEURONS    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_start;
  logic             bias_wr_en;
  logic [IDX_W-1:0] bias_wr_addr;
  logic [31:0]      bias_wr_data;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_result = '0;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             err;

  neural_stage_bias_seq #(.NEURONS(NEURONS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start),
    .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          last;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        out_log[$];
  rec_t        rec;
  logic [31:0] m_bias [NEURONS];
  logic [31:0] vals   [NEURONS];
  logic [37:0] prev_word;
  bit          prev_stall;
  int          m_idx, outstanding, cyc, done_cnt, last_cnt, first_acc, first_vld;
  int          n_checks, n_pass;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) - 11'd127 + 11'd1023, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd1023 + 11'd127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Stand-in for the shared adder: registered sum, one cycle of latency.
  always @(posedge clk) add_result <= fadd(add_a, add_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      exp_q.delete();
      m_idx       = 0;
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        check("add_a", add_a, in_data);
        check("add_b", add_b, m_bias[m_idx]);
        rec.data = fadd(in_data, m_bias[m_idx]);
        rec.idx  = m_idx;
        rec.last = (m_idx == NEURONS - 1);
        exp_q.push_back(rec);
        m_idx = (m_idx == NEURONS - 1) ? 0 : m_idx + 1;
        outstanding++;
        if (first_acc < 0) first_acc = cyc;
      end else begin
        check("add_idle", {add_a, add_b}, 64'd0);
      end
      if (prev_stall) check("out_stable", {out_valid, out_last, out_index, out_data}, prev_word);
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        check("out_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          rec = exp_q.pop_front();
          check("out_data", out_data, rec.data);
          check("out_index", out_index, rec.idx);
          check("out_last", out_last, rec.last);
          outstanding--;
        end
        rec.data = out_data;
        rec.idx  = int'(out_index);
        rec.last = out_last;
        out_log.push_back(rec);
        if (out_last) last_cnt++;
      end
      check("credit", outstanding <= FIFO_DEPTH, 1);
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_valid, out_last, out_index, out_data};
    end
  end

  task automatic write_bias(input int addr, input logic [31:0] data, input bit model);
    bias_wr_en   = 1'b1;
    bias_wr_addr = IDX_W'(addr);
    bias_wr_data = data;
    if (model) m_bias[addr] = data;
    @(posedge clk); #1;
    bias_wr_en = 1'b0;
  endtask

  task automatic start_frame();
    out_log.delete();
    done_cnt = 0; last_cnt = 0; first_acc = -1; first_vld = -1;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] v [NEURONS], input int first, input int vpct,
                            input int rpct);
    int i = first;
    int guard = 0;
    while (i < NEURONS && guard < 2000) begin
      in_valid  = ($urandom_range(99) < vpct);
      in_data   = v[i];
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    check("frame_accepts", i, NEURONS);
  endtask

  task automatic wait_done();
    int g = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    do begin
      @(negedge clk);
      g++;
    end while (busy && g < 200);
    check("drain_done", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int acc;
    reset = 1'b0; cfg_start = 1'b0; bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    first_acc = -1; first_vld = -1;

    // Reset state.
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    // Pin the model's float arithmetic on known sums.
    check("model_3p0", fadd(32'h40000000, 32'h3F800000), 32'h40400000);
    check("model_0p5", fadd(32'h3FC00000, 32'hBF800000), 32'h3F000000);

    // Frame 1: bias 1.0 everywhere, inputs 2.0, full throughput.
    for (int i = 0; i < NEURONS; i++) write_bias(i, 32'h3F800000, 1'b1);
    for (int i = 0; i < NEURONS; i++) vals[i] = 32'h40000000;
    start_frame();
    send_frame(vals, 0, 100, 100);
    wait_done();
    check("f1_count", out_log.size(), NEURONS);
    check("f1_first", out_log[0].data, 32'h40400000);
    check("f1_idx15", out_log[15].idx, 15);
    check("f1_last15", out_log[15].last, 1);
    check("f1_last_cnt", last_cnt, 1);
    check("f1_latency", first_vld - first_acc, 2);
    check("f1_done_cnt", done_cnt, 1);

    // Frame 2: negative bias on index 3.
    write_bias(3, 32'hBF800000, 1'b1);
    vals[3] = 32'h3FC00000;
    start_frame();
    send_frame(vals, 0, 100, 100);
    wait_done();
    check("f2_idx3", out_log[3].data, 32'h3F000000);
    check("f2_idx2", out_log[2].data, 32'h40400000);
    check("f2_idx4", out_log[4].data, 32'h40400000);

    // Backpressure: out_ready low for 10 cycles admits exactly FIFO_DEPTH values.
    for (int i = 0; i < NEURONS; i++) vals[i] = r2f(real'(i + 1));
    start_frame();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = vals[acc];
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepts", acc, 4);
    check("bp_in_ready", in_ready, 0);
    send_frame(vals, acc, 100, 100);
    wait_done();
    check("bp_count", out_log.size(), NEURONS);
    check("bp_out0", out_log[0].data, 32'h40000000);
    check("bp_out3", out_log[3].data, 32'h40400000);
    for (int i = 0; i < NEURONS; i++) check("bp_order", out_log[i].idx, i);

    // Three frames with random valid/ready.
    begin
      rec_t all_log[$];
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < NEURONS; i++) vals[i] = r2f(real'($urandom_range(64, 1)));
        start_frame();
        send_frame(vals, 0, 60, 60);
        wait_done();
        check("rnd_done", done_cnt, 1);
        foreach (out_log[k]) all_log.push_back(out_log[k]);
      end
      check("rnd_count", all_log.size(), 3 * NEURONS);
      for (int i = 0; i < all_log.size(); i++) check("rnd_index", all_log[i].idx, i % NEURONS);
      check("rnd_err", err, 0);
      check("rnd_queue_empty", exp_q.size(), 0);
    end

    // Bias write and cfg_start during RUN are dropped and flag err.
    for (int i = 0; i < NEURONS; i++) vals[i] = 32'h40000000;
    start_frame();
    cfg_start = 1'b1;
    write_bias(5, 32'h12345678, 1'b0);
    cfg_start = 1'b0;
    check("run_err_set", err, 1);
    send_frame(vals, 0, 100, 100);
    wait_done();
    check("run_idx5", out_log[5].data, 32'h40400000);
    check("run_count", out_log.size(), NEURONS);
    check("run_done_cnt", done_cnt, 1);
    check("run_err_sticky", err, 1);

    // Asynchronous reset at index 7, then a clean frame.
    start_frame();
    out_ready = 1'b1;
    acc = 0;
    while (acc < 7) begin
      in_valid = 1'b1;
      in_data  = 32'h40000000;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    check("mid_out_valid_pre", out_valid, 1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_in_ready", in_ready, 0);
    check("mid_err", err, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    start_frame();
    send_frame(vals, 0, 100, 100);
    wait_done();
    check("post_count", out_log.size(), NEURONS);
    check("post_idx0", out_log[0].idx, 0);
    check("post_data0", out_log[0].data, 32'h40400000);
    check("post_done_cnt", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neural_stage_bias_seq.md
# neural_stage_bias_seq

Sequencer that feeds one neural-stage output frame through the shared bias floating-point adder. For each incoming accumulated value it selects the bias for the current neuron index from an internal bias table and drives the adder. It then captures the adder's registered result into a small output FIFO, with valid/ready flow control on both sides. It sits between the neural-stage accumulator and the activation stage and owns the adder's operand inputs.

## Interface
- NEURONS, 16, neurons per frame (≥2); index width IDX_W = clog2(NEURONS)
- FIFO_DEPTH, 4, output FIFO entries (fixed ≥3 for full throughput)
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- cfg_start  input  1  start one frame (honoured in IDLE only)
- bias_wr_en  input  1  bias table write strobe (honoured in IDLE only)
- bias_wr_addr  input  IDX_W  bias table index
- bias_wr_data  input  32  float_24_8 bias {sgn, exp[7:0], man[22:0]}
- in_valid / in_ready  input / output  1  accumulator handshake
- in_data  input  32  float_24_8 accumulated value
- add_a  output  32  adder operand (accumulated value)
- add_b  output  32  adder operand (bias)
- add_result  input  32  adder registered sum (1-cycle latency, registers every cycle)
- out_valid / out_ready  output / input  1  result handshake
- out_data  output  32  biased value
- out_index  output  IDX_W  neuron index of out_data
- out_last  output  1  out_index == NEURONS-1
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse on DRAIN→IDLE
- err  output  1  sticky: bias write outside IDLE, or cfg_start outside IDLE

## Operation
- Bias table: NEURONS×32 registers, written in IDLE. Not cleared by reset (contents undefined until written). Writes in other states are dropped and set err.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: cfg_start → RUN, with idx←0.
  - RUN: on each accept (in_valid & in_ready), idx increments. Accepting idx NEURONS-1 → DRAIN, with idx←0.
  - DRAIN: when inflight==0 and the FIFO is empty → IDLE, and pulse done.
- in_ready = (state==RUN) & (fifo_count + inflight < FIFO_DEPTH). It does not depend on out_ready.
- On an accept, add_a = in_data and add_b = bias[idx] combinationally in the same cycle. inflight←1 with the tag {idx, last}; otherwise inflight←0.
- When inflight==1, add_result is pushed into the FIFO with its tag. The credit check guarantees the push never overflows.
- When no accept occurs, add_a and add_b are driven to 0. The adder output is ignored in that case.
- FIFO head drives out_data, out_index and out_last. out_valid = fifo_count≠0. A pop occurs on out_valid & out_ready. A push and a pop in the same cycle leave the count unchanged.
- cfg_start while busy is ignored and sets err. err is cleared only by reset.
- Reset (asynchronous assertion at any time, including mid-frame) forces IDLE and clears idx, inflight, FIFO pointers/count, done and err. Any in-progress frame is discarded.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, out_index 0, out_last 0, add_a 0, add_b 0, busy 0, done 0, err 0.
- Latency: accept at cycle N → adder captures at the end of N → FIFO push at the end of N+1 → out_valid at N+2 (earliest).
- Throughput: with out_ready held high, one result per cycle.
- Backpressure: with out_ready low, at most FIFO_DEPTH results are outstanding (FIFO plus inflight). in_ready falls in the cycle the sum reaches FIFO_DEPTH.
- out_data, out_index and out_last are stable while out_valid & !out_ready.
- DRAIN lasts at least 2 cycles (the last inflight result, then the pop).
- done is asserted in the first IDLE cycle. cfg_start is accepted on that same cycle.

## Test plan
- Load bias[0..15]=0x3F800000 (1.0); start; stream 16 inputs of 0x40000000 (2.0) with out_ready=1 → 16 outputs of 0x40400000 (3.0), indices 0..15, out_last on index 15 only, first out_valid 2 cycles after the first accept, done once.
- bias[3]=0xBF800000 (-1.0), in[3]=0x3FC00000 (1.5) → out at index 3 = 0x3F000000 (0.5); other indices unaffected.
- Hold out_ready=0 for 10 cycles → exactly 4 accepts, then in_ready=0. Release → outputs in order with no loss or duplication.
- Random in_valid/out_ready toggling over 3 back-to-back frames → output order and indices match a reference model, err=0.
- bias_wr_en and cfg_start asserted during RUN → bias unchanged, frame unaffected, err=1 sticky.
- Assert reset at index 7 mid-frame → in the same cycle out_valid=0, busy=0, in_ready=0. A new frame then starts cleanly at index 0.
